// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage for the two-thread Ember core.
//
// Picks an enabled thread round-robin, issues a single L1I read for that
// thread's PC, waits for the returned word, and presents {inst, pc, tid} to
// decode on a valid/ready handshake. Only one read is ever outstanding.
// Branch/exec redirects load a new PC and squash any fetch for that thread
// that is still in flight or waiting in the output register.
//
// Ports:
//   clk, rst                      core clock; asynchronous active-high reset
//   t0_enable, t1_enable          per-thread fetch permission
//   l1i_rd_en, l1i_addr           one-cycle read strobe and 4-aligned byte address
//   l1i_rd_data, l1i_rd_valid     little-endian read word and its valid
//   redirect_valid/_tid/_pc       PC redirect for one thread (pc[1:0] ignored)
//   out_valid, out_ready          handshake to decode
//   out_inst, out_pc, out_tid     delivered instruction, its PC and owning thread
module fetch_unit #(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                INST_B   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              t0_enable,
    input  logic              t1_enable,
    output logic              l1i_rd_en,
    output logic [ADDR_W-1:0] l1i_addr,
    input  logic [31:0]       l1i_rd_data,
    input  logic              l1i_rd_valid,
    input  logic              redirect_valid,
    input  logic              redirect_tid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_inst,
    output logic [ADDR_W-1:0] out_pc,
    output logic              out_tid
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc0_q, pc0_d;
    logic [ADDR_W-1:0] pc1_q, pc1_d;
    logic              rr_ptr_q, rr_ptr_d;
    logic              discard_q, discard_d;
    logic              req_tid_q, req_tid_d;
    logic [ADDR_W-1:0] req_pc_q, req_pc_d;
    logic [31:0]       inst_q, inst_d;

    logic              any_en;
    logic              rr_en;
    logic              sel;
    logic [ADDR_W-1:0] sel_pc;
    logic [ADDR_W-1:0] redir_pc;
    logic              redir_hit;
    logic              stale;
    logic              kill;

    always_comb begin
        any_en    = t0_enable | t1_enable;
        rr_en     = rr_ptr_q ? t1_enable : t0_enable;
        sel       = rr_en ? rr_ptr_q : ~rr_ptr_q;
        sel_pc    = sel ? pc1_q : pc0_q;
        // Masking keeps every redirect_pc bit referenced while forcing alignment.
        redir_pc  = redirect_pc & ~ADDR_W'(3);
        redir_hit = redirect_valid & (redirect_tid == req_tid_q);
        // A redirect arriving in the same cycle as the data makes that data stale too.
        stale     = discard_q | redir_hit;
        kill      = (state_q == S_HOLD) & redir_hit;
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            pc0_q     <= RESET_PC;
            pc1_q     <= RESET_PC;
            rr_ptr_q  <= 1'b0;
            discard_q <= 1'b0;
            req_tid_q <= 1'b0;
            req_pc_q  <= '0;
            inst_q    <= '0;
        end else begin
            state_q   <= state_d;
            pc0_q     <= pc0_d;
            pc1_q     <= pc1_d;
            rr_ptr_q  <= rr_ptr_d;
            discard_q <= discard_d;
            req_tid_q <= req_tid_d;
            req_pc_q  <= req_pc_d;
            inst_q    <= inst_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d   = state_q;
        pc0_d     = pc0_q;
        pc1_d     = pc1_q;
        rr_ptr_d  = rr_ptr_q;
        discard_d = discard_q;
        req_tid_d = req_tid_q;
        req_pc_d  = req_pc_q;
        inst_d    = inst_q;

        case (state_q)
            S_IDLE: begin
                if (any_en) state_d = S_REQ;
            end
            S_REQ: begin
                // Enables are re-sampled here so a thread disabled after IDLE never fetches.
                if (any_en) begin
                    state_d   = S_WAIT;
                    req_tid_d = sel;
                    req_pc_d  = sel_pc;
                    rr_ptr_d  = ~sel;
                    // The read just issued used the old PC of the redirected thread.
                    if (redirect_valid && (redirect_tid == sel)) discard_d = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT: begin
                if (l1i_rd_valid) begin
                    if (stale) begin
                        discard_d = 1'b0;
                        state_d   = S_IDLE;
                    end else begin
                        inst_d  = l1i_rd_data;
                        state_d = S_HOLD;
                    end
                end else if (redir_hit) begin
                    discard_d = 1'b1;
                end
            end
            S_HOLD: begin
                if (out_ready || kill) begin
                    state_d = any_en ? S_REQ : S_IDLE;
                    if (!kill) begin
                        if (req_tid_q) pc1_d = pc1_q + ADDR_W'(INST_B);
                        else           pc0_d = pc0_q + ADDR_W'(INST_B);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Redirect is applied last so it overrides any same-cycle increment.
        if (redirect_valid) begin
            if (redirect_tid) pc1_d = redir_pc;
            else              pc0_d = redir_pc;
        end
    end

    // Outputs
    always_comb begin
        l1i_rd_en = (state_q == S_REQ) & any_en;
        l1i_addr  = l1i_rd_en ? sel_pc : '0;
        out_valid = (state_q == S_HOLD);
        out_inst  = inst_q;
        out_pc    = req_pc_q;
        out_tid   = req_tid_q;
    end

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        t0_enable = 1'b0;
    logic        t1_enable = 1'b0;
    logic        l1i_rd_en;
    logic [31:0] l1i_addr;
    logic [31:0] l1i_rd_data;
    logic        l1i_rd_valid;
    logic        redirect_valid = 1'b0;
    logic        redirect_tid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
    logic        out_tid;

    int n_chk = 0;
    int n_err = 0;

    // L1I model: responds one cycle after the strobe when mem_on is set;
    // man_vld/man_data let the bench inject returns by hand.
    logic [7:0]  mem [0:511];
    logic        mem_on = 1'b0;
    logic        auto_vld = 1'b0;
    logic [31:0] auto_data = '0;
    logic        man_vld = 1'b0;
    logic [31:0] man_data = '0;
    logic        seen_ov = 1'b0;

    fetch_unit #(.ADDR_W(32), .RESET_PC(32'h0), .INST_B(4)) dut (
        .clk(clk), .rst(rst),
        .t0_enable(t0_enable), .t1_enable(t1_enable),
        .l1i_rd_en(l1i_rd_en), .l1i_addr(l1i_addr),
        .l1i_rd_data(l1i_rd_data), .l1i_rd_valid(l1i_rd_valid),
        .redirect_valid(redirect_valid), .redirect_tid(redirect_tid),
        .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_inst(out_inst), .out_pc(out_pc), .out_tid(out_tid)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rd_word(input logic [31:0] a);
        logic [8:0] b;
        b = a[8:0];
        return {mem[b+9'd3], mem[b+9'd2], mem[b+9'd1], mem[b]};
    endfunction

    always @(posedge clk) begin
        auto_vld  <= mem_on & l1i_rd_en;
        auto_data <= rd_word(l1i_addr);
    end

    assign l1i_rd_valid = auto_vld | man_vld;
    assign l1i_rd_data  = auto_vld ? auto_data : man_data;

    always @(negedge clk) if (out_valid) seen_ov = 1'b1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic put_word(input int a, input logic [31:0] w);
        mem[a]   = w[7:0];
        mem[a+1] = w[15:8];
        mem[a+2] = w[23:16];
        mem[a+3] = w[31:24];
    endtask

    task automatic do_reset();
        rst = 1'b1;
        t0_enable = 1'b0; t1_enable = 1'b0;
        out_ready = 1'b0; redirect_valid = 1'b0;
        man_vld = 1'b0; mem_on = 1'b0;
        @(posedge clk); @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic wait_req(output logic [31:0] a);
        int k;
        k = 0;
        @(negedge clk);
        while (!l1i_rd_en && k < 40) begin
            @(negedge clk);
            k++;
        end
        if (!l1i_rd_en) begin
            check("req_timeout", {63'h0, l1i_rd_en}, 64'h1);
            a = 32'hxxxxxxxx;
        end else begin
            a = l1i_addr;
        end
    endtask

    task automatic wait_out(output logic [31:0] inst, output logic [31:0] pc, output logic tid);
        int k;
        k = 0;
        @(negedge clk);
        while (!out_valid && k < 40) begin
            @(negedge clk);
            k++;
        end
        if (!out_valid) check("out_timeout", {63'h0, out_valid}, 64'h1);
        inst = out_inst;
        pc   = out_pc;
        tid  = out_tid;
    endtask

    logic [31:0] a, inst, pc;
    logic        tid;

    initial begin
        for (int i = 0; i < 512; i++) mem[i] = 8'h00;
        mem[0] = 8'h15; mem[1] = 8'h10; mem[2] = 8'h08; mem[3] = 8'h12;
        put_word(32'h004, 32'hA1B2C3D4);
        put_word(32'h040, 32'h00400013);
        put_word(32'h100, 32'h10000093);
        put_word(32'h1FC, 32'hFFC0FFEE);

        // Reset state
        @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", {63'h0, out_valid}, 64'h0);
        check("rst_rd_en", {63'h0, l1i_rd_en}, 64'h0);
        check("rst_addr", {32'h0, l1i_addr}, 64'h0);
        check("rst_out_inst", {32'h0, out_inst}, 64'h0);

        // 1: single-thread fetch, byte order, next address
        do_reset();
        t0_enable = 1'b1; out_ready = 1'b1; mem_on = 1'b1;
        wait_out(inst, pc, tid);
        check("t1_inst", {32'h0, inst}, 64'h12081015);
        check("t1_pc", {32'h0, pc}, 64'h0);
        check("t1_tid", {63'h0, tid}, 64'h0);
        @(posedge clk);
        wait_req(a);
        check("t1_next_addr", {32'h0, a}, 64'h4);

        // 2: round-robin between two threads
        do_reset();
        t0_enable = 1'b1; t1_enable = 1'b1; out_ready = 1'b1; mem_on = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wait_out(inst, pc, tid);
            check("t2_tid", {63'h0, tid}, {63'h0, i[0]});
            check("t2_pc", {32'h0, pc}, (i < 2) ? 64'h0 : 64'h4);
            if (i == 2) check("t2_inst", {32'h0, inst}, 64'hA1B2C3D4);
            @(posedge clk);
        end

        // 3: back-pressure holds outputs stable, then exactly +4
        do_reset();
        t0_enable = 1'b1; mem_on = 1'b1;
        wait_out(inst, pc, tid);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); @(negedge clk);
            check("t3_vld_noreq", {62'h0, out_valid, l1i_rd_en}, 64'h2);
            check("t3_inst", {32'h0, out_inst}, 64'h12081015);
            check("t3_pc", {32'h0, out_pc}, 64'h0);
        end
        @(posedge clk); #1 out_ready = 1'b1;
        @(posedge clk); #1 out_ready = 1'b0;
        wait_req(a);
        check("t3_next_addr", {32'h0, a}, 64'h4);

        // 4: redirect while WAITing discards the stale word
        do_reset();
        t0_enable = 1'b1; out_ready = 1'b1;
        wait_req(a);
        check("t4_first_addr", {32'h0, a}, 64'h0);
        @(posedge clk);
        #1 redirect_valid = 1'b1; redirect_tid = 1'b0; redirect_pc = 32'h103;
        @(posedge clk);
        #1 redirect_valid = 1'b0; man_vld = 1'b1; man_data = 32'hDEADBEEF;
        @(posedge clk);
        #1 man_vld = 1'b0; mem_on = 1'b1; seen_ov = 1'b0;
        wait_req(a);
        check("t4_redir_addr", {32'h0, a}, 64'h100);
        check("t4_no_stale_out", {63'h0, seen_ov}, 64'h0);
        wait_out(inst, pc, tid);
        check("t4_inst", {32'h0, inst}, 64'h10000093);
        check("t4_pc", {32'h0, pc}, 64'h100);
        @(posedge clk);

        // Redirect in HOLD drops out_valid; redirect beats a colliding handshake
        do_reset();
        t0_enable = 1'b1; mem_on = 1'b1;
        wait_out(inst, pc, tid);
        @(posedge clk);
        #1 redirect_valid = 1'b1; redirect_tid = 1'b0; redirect_pc = 32'h40;
        @(posedge clk);
        #1 redirect_valid = 1'b0;
        @(negedge clk);
        check("hold_kill_vld", {63'h0, out_valid}, 64'h0);
        check("hold_kill_addr", {31'h0, l1i_rd_en, l1i_addr}, 64'h1_0000_0040);
        wait_out(inst, pc, tid);
        check("hold_kill_inst", {32'h0, inst}, 64'h00400013);
        out_ready = 1'b1;
        redirect_valid = 1'b1; redirect_tid = 1'b0; redirect_pc = 32'h80;
        @(posedge clk);
        #1 redirect_valid = 1'b0;
        wait_req(a);
        check("collide_addr", {32'h0, a}, 64'h80);

        // 5: PC wraps at the top of the address space
        do_reset();
        @(posedge clk);
        #1 redirect_valid = 1'b1; redirect_tid = 1'b0; redirect_pc = 32'hFFFFFFFC;
        @(posedge clk);
        #1 redirect_valid = 1'b0; t0_enable = 1'b1; out_ready = 1'b1; mem_on = 1'b1;
        wait_out(inst, pc, tid);
        check("t5_pc", {32'h0, pc}, 64'hFFFFFFFC);
        check("t5_inst", {32'h0, inst}, 64'hFFC0FFEE);
        @(posedge clk);
        wait_req(a);
        check("t5_wrap_addr", {32'h0, a}, 64'h0);

        // 6: reset during WAIT abandons the read; later rd_valid ignored
        do_reset();
        t0_enable = 1'b1; out_ready = 1'b1; mem_on = 1'b1;
        wait_out(inst, pc, tid);
        @(posedge clk);
        #1 mem_on = 1'b0;
        wait_req(a);
        check("t6_pre_addr", {32'h0, a}, 64'h4);
        @(posedge clk);
        #1 rst = 1'b1; t0_enable = 1'b0; seen_ov = 1'b0;
        man_vld = 1'b1; man_data = 32'hCAFEF00D;
        @(posedge clk);
        #1 man_vld = 1'b0; rst = 1'b0;
        @(posedge clk);
        #1 man_vld = 1'b1;
        @(posedge clk);
        #1 man_vld = 1'b0;
        @(posedge clk); @(negedge clk);
        check("t6_no_out", {63'h0, seen_ov}, 64'h0);
        t0_enable = 1'b1; mem_on = 1'b1;
        wait_req(a);
        check("t6_reset_pc", {32'h0, a}, 64'h0);
        wait_out(inst, pc, tid);
        check("t6_inst", {32'h0, inst}, 64'h12081015);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
